// File: rtl/midi_pkg.sv
// Shared types for the MIDI voice allocator: note/velocity widths, FSM states
// and the action recorded by the search stage.
package midi_pkg;

  localparam int MIDI_NOTE_W = 7;
  localparam int MIDI_VEL_W  = 7;

  typedef logic [MIDI_NOTE_W-1:0] midi_note_t;
  typedef logic [MIDI_VEL_W-1:0]  midi_vel_t;

  typedef enum logic [1:0] {
    IDLE,
    SEARCH,
    UPDATE
  } alloc_state_t;

  typedef enum logic [1:0] {
    ACT_ON,
    ACT_OFF,
    ACT_NONE
  } alloc_action_t;

endpackage

// File: rtl/midi_voice_select.sv
// Combinational priority search over the voice slots: note match, free voice,
// oldest voice and the set of held voices a note-off would release.
module midi_voice_select
  import midi_pkg::*;
#(
  parameter int NUMREADS = 4,
  localparam int IDX_W = $clog2(NUMREADS)
) (
  input  logic [MIDI_NOTE_W-1:0] notenums [0:NUMREADS-1],
  input  logic [NUMREADS-1:0]    gates,
  input  logic [IDX_W-1:0]       ages [0:NUMREADS-1],
  input  logic [MIDI_NOTE_W-1:0] note,
  output logic                   match_found,
  output logic [IDX_W-1:0]       match_idx,
  output logic                   free_found,
  output logic [IDX_W-1:0]       free_idx,
  output logic [IDX_W-1:0]       oldest_idx,
  output logic [NUMREADS-1:0]    off_mask
);

  // Scanning from the top down lets the lowest-index hit overwrite any other.
  // NOTE: every output gets a default before the loop, so no latch can be inferred.
  always_comb begin
    match_found = 1'b0;
    match_idx   = '0;
    free_found  = 1'b0;
    free_idx    = '0;
    oldest_idx  = '0;
    off_mask    = '0;
    for (int i = NUMREADS - 1; i >= 0; i--) begin
      if (notenums[i] == note) begin
        match_found = 1'b1;
        match_idx   = IDX_W'(i);
      end
      if (!gates[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
      if (ages[i] == IDX_W'(NUMREADS - 1)) begin
        oldest_idx = IDX_W'(i);
      end
      off_mask[i] = gates[i] && (notenums[i] == note);
    end
  end

endmodule

// File: rtl/midi_voice_allocator.sv
// Assigns note-on/off events to voice slots with retrigger, free allocation,
// oldest-voice stealing and panic; one event per three cycles.
module midi_voice_allocator
  import midi_pkg::*;
#(
  parameter int NUMREADS = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   panic,
  input  logic                   event_valid,
  output logic                   event_ready,
  input  logic                   event_note_on,
  input  logic [MIDI_NOTE_W-1:0] event_note,
  input  logic [MIDI_VEL_W-1:0]  event_velocity,
  output logic [MIDI_NOTE_W-1:0] midi_notenums [0:NUMREADS-1],
  output logic [NUMREADS-1:0]    voice_gate,
  output logic [MIDI_VEL_W-1:0]  voice_velocity [0:NUMREADS-1],
  output logic [NUMREADS-1:0]    voice_trigger
);

  localparam int IDX_W = $clog2(NUMREADS);

  alloc_state_t  state, state_next;
  alloc_action_t action;
  midi_note_t    ev_note;
  midi_vel_t     ev_vel;
  logic          ev_on;
  logic [IDX_W-1:0]    tgt_idx;
  logic [NUMREADS-1:0] off_mask_q;
  logic [IDX_W-1:0]    ages [0:NUMREADS-1];

  logic                accept;
  logic                match_found, free_found;
  logic [IDX_W-1:0]    match_idx, free_idx, oldest_idx;
  logic [NUMREADS-1:0] off_mask;

  assign event_ready = (state == IDLE) && !panic && !reset;
  assign accept      = event_valid && event_ready;

  midi_voice_select #(.NUMREADS(NUMREADS)) u_select (
    .notenums    (midi_notenums),
    .gates       (voice_gate),
    .ages        (ages),
    .note        (ev_note),
    .match_found (match_found),
    .match_idx   (match_idx),
    .free_found  (free_found),
    .free_idx    (free_idx),
    .oldest_idx  (oldest_idx),
    .off_mask    (off_mask)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (accept) state_next = SEARCH;
      SEARCH:  state_next = UPDATE;
      UPDATE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (panic) state_next = IDLE;
  end

  // Velocity 0 on a note-on is folded into a note-off when the event is taken.
  always_ff @(posedge clk) begin
    if (accept) begin
      ev_note <= event_note;
      ev_vel  <= event_velocity;
      ev_on   <= event_note_on && (event_velocity != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (state == SEARCH) begin
      off_mask_q <= off_mask;
      if (ev_on) begin
        action <= ACT_ON;
        if (match_found)     tgt_idx <= match_idx;
        else if (free_found) tgt_idx <= free_idx;
        else                 tgt_idx <= oldest_idx;
      end else begin
        action  <= (|off_mask) ? ACT_OFF : ACT_NONE;
        tgt_idx <= '0;
      end
    end
  end

  // Voice registers; panic wins over a coincident UPDATE write.
  always_ff @(posedge clk) begin
    if (reset) begin
      voice_gate    <= '0;
      voice_trigger <= '0;
      for (int i = 0; i < NUMREADS; i++) begin
        midi_notenums[i]  <= '0;
        voice_velocity[i] <= '0;
        ages[i]           <= IDX_W'(i);
      end
    end else begin
      voice_trigger <= '0;
      if (panic) begin
        voice_gate <= '0;
      end else if (state == UPDATE) begin
        unique case (action)
          ACT_ON: begin
            midi_notenums[tgt_idx]  <= ev_note;
            voice_velocity[tgt_idx] <= ev_vel;
            voice_gate[tgt_idx]     <= 1'b1;
            voice_trigger           <= NUMREADS'(1) << tgt_idx;
            for (int i = 0; i < NUMREADS; i++) begin
              if (ages[i] < ages[tgt_idx]) ages[i] <= ages[i] + 1'b1;
            end
            ages[tgt_idx] <= '0;
          end
          ACT_OFF: voice_gate <= voice_gate & ~off_mask_q;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_midi_voice_allocator.sv
// Directed bench for midi_voice_allocator: allocation order, stealing,
// note-off, retrigger, velocity-0 handling, panic and reset mid-event.
module tb_midi_voice_allocator;

  logic       clk = 1'b0;
  logic       reset, panic, event_valid, event_ready, event_note_on;
  logic [6:0] event_note, event_velocity;
  logic [6:0] midi_notenums [0:3];
  logic [3:0] voice_gate;
  logic [6:0] voice_velocity [0:3];
  logic [3:0] voice_trigger;

  int vectors = 0;
  int miscompares = 0;

  midi_voice_allocator #(.NUMREADS(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .panic          (panic),
    .event_valid    (event_valid),
    .event_ready    (event_ready),
    .event_note_on  (event_note_on),
    .event_note     (event_note),
    .event_velocity (event_velocity),
    .midi_notenums  (midi_notenums),
    .voice_gate     (voice_gate),
    .voice_velocity (voice_velocity),
    .voice_trigger  (voice_trigger)
  );

  always #5 clk = ~clk;

  function automatic logic [27:0] notes_obs();
    return {midi_notenums[0], midi_notenums[1], midi_notenums[2], midi_notenums[3]};
  endfunction

  function automatic logic [27:0] vels_obs();
    return {voice_velocity[0], voice_velocity[1], voice_velocity[2], voice_velocity[3]};
  endfunction

  // Waits for ready, presents one event, and returns one cycle after the
  // trigger slot (E2+1 -> E3+1) with the observed ready/trigger history.
  task automatic send_event(input logic on, input logic [6:0] note, input logic [6:0] vel,
                            output logic [3:0] trig_e2, output logic [3:0] trig_e3,
                            output logic [2:0] ready_seen);
    int n = 0;
    while (!event_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    vectors++;
    if (n >= 20) begin
      miscompares++;
      $display("FAIL ready_timeout: event_ready stayed %b, expected 1", event_ready);
    end
    event_valid = 1'b1; event_note_on = on; event_note = note; event_velocity = vel;
    @(posedge clk); #1;
    event_valid = 1'b0;
    ready_seen[0] = event_ready;
    @(posedge clk); #1;
    ready_seen[1] = event_ready;
    @(posedge clk); #1;
    ready_seen[2] = event_ready;
    trig_e2 = voice_trigger;
    @(posedge clk); #1;
    trig_e3 = voice_trigger;
  endtask

  task automatic test_reset();
    reset = 1'b1; panic = 1'b0; event_valid = 1'b0;
    event_note_on = 1'b0; event_note = '0; event_velocity = '0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (event_ready !== 1'b0) begin
      miscompares++; $display("FAIL reset_ready_low: got %b expected 0", event_ready);
    end
    vectors++;
    if (notes_obs() !== 28'd0 || vels_obs() !== 28'd0) begin
      miscompares++; $display("FAIL reset_regs: notes %h vels %h expected 0", notes_obs(), vels_obs());
    end
    vectors++;
    if (voice_gate !== 4'b0000 || voice_trigger !== 4'b0000) begin
      miscompares++; $display("FAIL reset_gate_trig: gate %b trig %b expected 0000", voice_gate, voice_trigger);
    end
    reset = 1'b0;
    #1;
    vectors++;
    if (event_ready !== 1'b1) begin
      miscompares++; $display("FAIL reset_release_ready: got %b expected 1", event_ready);
    end
  endtask

  task automatic test_single_note_on();
    logic [3:0] t2, t3; logic [2:0] rs;
    send_event(1'b1, 7'd60, 7'd100, t2, t3, rs);
    vectors++;
    if (rs !== 3'b100) begin
      miscompares++; $display("FAIL single_ready_seq: got %b expected 100", rs);
    end
    vectors++;
    if (notes_obs() !== {7'd60, 7'd0, 7'd0, 7'd0}) begin
      miscompares++; $display("FAIL single_notes: got %h expected %h", notes_obs(), {7'd60, 21'd0});
    end
    vectors++;
    if (voice_gate !== 4'b0001 || vels_obs() !== {7'd100, 21'd0}) begin
      miscompares++; $display("FAIL single_gate_vel: gate %b vels %h expected 0001 %h", voice_gate, vels_obs(), {7'd100, 21'd0});
    end
    vectors++;
    if (t2 !== 4'b0001 || t3 !== 4'b0000) begin
      miscompares++; $display("FAIL single_trigger: got %b then %b expected 0001 then 0000", t2, t3);
    end
  endtask

  task automatic test_fill_and_steal();
    logic [3:0] t2, t3; logic [2:0] rs;
    send_event(1'b1, 7'd62, 7'd80, t2, t3, rs);
    send_event(1'b1, 7'd64, 7'd80, t2, t3, rs);
    send_event(1'b1, 7'd67, 7'd80, t2, t3, rs);
    vectors++;
    if (notes_obs() !== {7'd60, 7'd62, 7'd64, 7'd67} || voice_gate !== 4'b1111) begin
      miscompares++; $display("FAIL fill_order: notes %h gate %b expected %h 1111", notes_obs(), voice_gate, {7'd60, 7'd62, 7'd64, 7'd67});
    end
    send_event(1'b1, 7'd69, 7'd90, t2, t3, rs);
    vectors++;
    if (t2 !== 4'b0001) begin
      miscompares++; $display("FAIL steal_trigger: got %b expected 0001", t2);
    end
    vectors++;
    if (notes_obs() !== {7'd69, 7'd62, 7'd64, 7'd67} || vels_obs() !== {7'd90, 7'd80, 7'd80, 7'd80}) begin
      miscompares++; $display("FAIL steal_voices: notes %h vels %h expected %h %h", notes_obs(), vels_obs(), {7'd69, 7'd62, 7'd64, 7'd67}, {7'd90, 7'd80, 7'd80, 7'd80});
    end
  endtask

  task automatic test_note_off_realloc();
    logic [3:0] t2, t3; logic [2:0] rs;
    send_event(1'b0, 7'd62, 7'd0, t2, t3, rs);
    vectors++;
    if (voice_gate !== 4'b1101 || t2 !== 4'b0000) begin
      miscompares++; $display("FAIL note_off_gate: gate %b trig %b expected 1101 0000", voice_gate, t2);
    end
    vectors++;
    if (notes_obs() !== {7'd69, 7'd62, 7'd64, 7'd67}) begin
      miscompares++; $display("FAIL note_off_retain: got %h expected %h", notes_obs(), {7'd69, 7'd62, 7'd64, 7'd67});
    end
    send_event(1'b1, 7'd71, 7'd70, t2, t3, rs);
    vectors++;
    if (t2 !== 4'b0010 || notes_obs() !== {7'd69, 7'd71, 7'd64, 7'd67} || voice_gate !== 4'b1111) begin
      miscompares++; $display("FAIL realloc_free: trig %b notes %h gate %b expected 0010 %h 1111", t2, notes_obs(), voice_gate, {7'd69, 7'd71, 7'd64, 7'd67});
    end
  endtask

  task automatic test_retrigger();
    logic [3:0] t2, t3; logic [2:0] rs;
    send_event(1'b1, 7'd64, 7'd50, t2, t3, rs);
    vectors++;
    if (t2 !== 4'b0100) begin
      miscompares++; $display("FAIL retrigger_trigger: got %b expected 0100", t2);
    end
    vectors++;
    if (notes_obs() !== {7'd69, 7'd71, 7'd64, 7'd67} || vels_obs() !== {7'd90, 7'd70, 7'd50, 7'd80}) begin
      miscompares++; $display("FAIL retrigger_voices: notes %h vels %h expected %h %h", notes_obs(), vels_obs(), {7'd69, 7'd71, 7'd64, 7'd67}, {7'd90, 7'd70, 7'd50, 7'd80});
    end
    // Ages are now v0=2 v1=1 v2=0 v3=3, so the next steal must take voice 3.
    send_event(1'b1, 7'd80, 7'd60, t2, t3, rs);
    vectors++;
    if (t2 !== 4'b1000 || notes_obs() !== {7'd69, 7'd71, 7'd64, 7'd80}) begin
      miscompares++; $display("FAIL steal_after_retrigger: trig %b notes %h expected 1000 %h", t2, notes_obs(), {7'd69, 7'd71, 7'd64, 7'd80});
    end
  endtask

  task automatic test_vel0_and_unmatched();
    logic [3:0] t2, t3; logic [2:0] rs;
    send_event(1'b1, 7'd64, 7'd0, t2, t3, rs);
    vectors++;
    if (voice_gate !== 4'b1011 || t2 !== 4'b0000 || vels_obs() !== {7'd90, 7'd70, 7'd50, 7'd60}) begin
      miscompares++; $display("FAIL vel0_is_off: gate %b trig %b vels %h expected 1011 0000 %h", voice_gate, t2, vels_obs(), {7'd90, 7'd70, 7'd50, 7'd60});
    end
    send_event(1'b0, 7'd99, 7'd0, t2, t3, rs);
    vectors++;
    if (rs !== 3'b100) begin
      miscompares++; $display("FAIL unmatched_ready_seq: got %b expected 100", rs);
    end
    vectors++;
    if (voice_gate !== 4'b1011 || t2 !== 4'b0000 || notes_obs() !== {7'd69, 7'd71, 7'd64, 7'd80}) begin
      miscompares++; $display("FAIL unmatched_noop: gate %b trig %b notes %h expected 1011 0000 %h", voice_gate, t2, notes_obs(), {7'd69, 7'd71, 7'd64, 7'd80});
    end
  endtask

  task automatic test_panic();
    logic [3:0] trig_or = 4'b0000;
    event_valid = 1'b1; event_note_on = 1'b1; event_note = 7'd72; event_velocity = 7'd30;
    @(posedge clk); #1;
    event_valid = 1'b0;
    panic = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (voice_gate !== 4'b0000 || voice_trigger !== 4'b0000 || event_ready !== 1'b0) begin
      miscompares++; $display("FAIL panic_edge: gate %b trig %b ready %b expected 0000 0000 0", voice_gate, voice_trigger, event_ready);
    end
    panic = 1'b0;
    #1;
    vectors++;
    if (event_ready !== 1'b1) begin
      miscompares++; $display("FAIL panic_release_ready: got %b expected 1", event_ready);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      trig_or |= voice_trigger;
    end
    vectors++;
    if (trig_or !== 4'b0000 || voice_gate !== 4'b0000 || notes_obs() !== {7'd69, 7'd71, 7'd64, 7'd80}) begin
      miscompares++; $display("FAIL panic_discard: trig %b gate %b notes %h expected 0000 0000 %h", trig_or, voice_gate, notes_obs(), {7'd69, 7'd71, 7'd64, 7'd80});
    end
  endtask

  task automatic test_reset_during_update();
    logic [3:0] t2, t3; logic [2:0] rs;
    event_valid = 1'b1; event_note_on = 1'b1; event_note = 7'd72; event_velocity = 7'd30;
    @(posedge clk); #1;
    event_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (notes_obs() !== 28'd0 || vels_obs() !== 28'd0 || voice_gate !== 4'b0000 || voice_trigger !== 4'b0000) begin
      miscompares++; $display("FAIL reset_in_update: notes %h vels %h gate %b trig %b expected all 0", notes_obs(), vels_obs(), voice_gate, voice_trigger);
    end
    vectors++;
    if (event_ready !== 1'b0) begin
      miscompares++; $display("FAIL reset_in_update_ready: got %b expected 0", event_ready);
    end
    reset = 1'b0;
    send_event(1'b1, 7'd72, 7'd30, t2, t3, rs);
    vectors++;
    if (t2 !== 4'b0001 || notes_obs() !== {7'd72, 21'd0} || voice_gate !== 4'b0001) begin
      miscompares++; $display("FAIL post_reset_alloc: trig %b notes %h gate %b expected 0001 %h 0001", t2, notes_obs(), voice_gate, {7'd72, 21'd0});
    end
  endtask

  initial begin
    test_reset();
    test_single_note_on();
    test_fill_and_steal();
    test_note_off_realloc();
    test_retrigger();
    test_vel0_and_unmatched();
    test_panic();
    test_reset_during_update();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/midi_voice_allocator.md
Name: midi_voice_allocator

Overview:
Upstream neighbour of the MIDI-note-to-table-index stage. Accepts a stream of note-on/note-off events over a valid/ready handshake and assigns them to NUMREADS voice slots. Drives the per-voice `midi_notenums` array consumed by the table-index stage, plus gate, velocity and one-cycle trigger per voice for the envelope/operator logic. Handles retrigger, free-voice allocation, oldest-voice stealing and panic.

Parameters:
NUMREADS, 4, number of voice slots; must match the downstream table-index stage (≥2)

Ports:
clk  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
panic  in  1  all-notes-off request, sampled each cycle
event_valid  in  1  event present
event_ready  out  1  allocator can accept an event this cycle
event_note_on  in  1  1 = note-on, 0 = note-off
event_note  in  7  MIDI note number
event_velocity  in  7  MIDI velocity
midi_notenums  out  7 x NUMREADS  note number per voice (unpacked array [0:NUMREADS-1])
voice_gate  out  NUMREADS  1 = key held on that voice
voice_velocity  out  7 x NUMREADS  velocity latched at last allocation
voice_trigger  out  NUMREADS  one-cycle pulse on (re)allocation

Behaviour:
- Reset:
  - FSM = IDLE.
  - `midi_notenums`, `voice_velocity` = 0; `voice_gate`, `voice_trigger` = 0.
  - age[i] = i, so voice NUMREADS-1 is the oldest.
  - `event_ready` = 0 while `reset` is high.
  - Reset mid-operation drops any in-flight event.
- `event_ready` = (state == IDLE) && !panic && !reset. An event is accepted on a clock edge where valid && ready; note, on-flag and velocity are latched.
- FSM:
  - IDLE → SEARCH on accept.
  - SEARCH → UPDATE unconditionally; the registered search result is target voice + action.
  - UPDATE → IDLE; voice registers are written at this edge.
  - Accept at edge E0; voice outputs change at E2; `voice_trigger` is high for the cycle after E2; next accept is possible at E3. Throughput is one event per 3 cycles.
- Note-on with velocity 0 is treated as a note-off (MIDI convention).
- Note-on target, first match wins:
  1. Lowest-index voice whose `midi_notenums` equals the note, gate high or low (retrigger).
  2. Lowest-index voice with gate = 0.
  3. Voice with age == NUMREADS-1 (steal oldest).
- Note-on update of target v:
  - notenum[v] = note, velocity[v] = vel, gate[v] = 1, trigger[v] pulses.
  - Age: every voice with age < age[v] increments, then age[v] = 0.
  - Ages always remain a permutation of 0..NUMREADS-1.
- Note-off:
  - Every voice with gate = 1 and matching note gets gate = 0.
  - Notenum and velocity are retained for the release phase; no trigger; ages unchanged.
  - An unmatched note-off is a no-op but still takes 3 cycles.
- Panic (any state):
  - All gates are cleared at that edge.
  - An in-flight event is discarded: no UPDATE write, no trigger. FSM goes to IDLE.
  - Notenums, velocities and ages are retained.
  - Panic has priority over a simultaneous UPDATE.
- At most one `voice_trigger` bit is high in any cycle.
- All outputs are registered; no combinational path from event inputs to outputs.

Decomposition:
- Package midi_pkg:
  - MIDI_NOTE_W = 7, MIDI_VEL_W = 7.
  - typedef `midi_note_t` / `midi_vel_t`.
  - enum `alloc_state_t` {IDLE, SEARCH, UPDATE}.
  - enum `alloc_action_t` {ACT_ON, ACT_OFF, ACT_NONE}.
- Sub-module midi_voice_select: purely combinational priority search.
  - Inputs: notenums, gates, ages, note.
  - Outputs: match_found/idx, free_found/idx, oldest_idx, off_mask.
  - Instantiated once and registered in SEARCH.

Test Plan:
- Reset, note-on 60 vel 100 accepted at E0 → at E2 voice0: notenum 60, gate 1, velocity 100; `voice_trigger` = 4'b0001 for exactly one cycle; `event_ready` low for 2 cycles after E0.
- Note-ons 60, 62, 64, 67 then 69 → voices 0–3 filled in order; 69 steals voice0 (age 3): notenum[0] = 69, trigger[0] pulses, other voices untouched.
- From 4 held notes, note-off 62 → gate[1] = 0, notenum[1] stays 62, no trigger; then note-on 71 → voice1 gets 71.
- Note-on 64 while held on voice2 → retrigger voice2 (trigger[2], velocity updated); no other voice changes; voice2 age becomes 0.
- Note-on 64 vel 0 → behaves as note-off (gate[2] = 0); note-off 99 with no match → all outputs unchanged, `event_ready` returns after 3 cycles.
- Panic asserted during SEARCH of note-on 72 → all gates 0 at that edge, no trigger, notenums unchanged; `event_ready` high the cycle after panic deasserts; `reset` asserted during UPDATE → all outputs return to reset values.
